// File: rtl/axis_fifo_arbiter_4_1.sv
// axis_fifo_arbiter_4_1
// Per-FIFO 4:1 frame arbiter. It grants one of four frame decoders (fd0..fd3)
// in round-robin order and holds the grant for a whole AXI-Stream frame. It
// muxes the winner's tvalid/tdata/tlast onto the FIFO write port and drives
// bus_sel, which the downstream tready demux uses to steer tready back.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   fifo_req[3:0]             per-decoder level request for this FIFO
//   axis_in_N_t*              decoder N stream (N = 0..3)
//   axis_out_t*               FIFO write stream (tready used only to detect beats)
//   bus_sel[3:0]              registered grant code for the tready demux
//   arb_timeout               one-cycle pulse on a forced release
//
// Optional feature: define ARB_TIMEOUT_EN to release a grant that has stalled
// for TIMEOUT_CYCLES cycles. Without it arb_timeout is tied low.
module axis_fifo_arbiter_4_1 #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter logic [3:0]  CHOOSE_FIFO_0   = 4'b0100,
    parameter logic [3:0]  CHOOSE_FIFO_1   = 4'b0101,
    parameter logic [3:0]  CHOOSE_FIFO_2   = 4'b0110,
    parameter logic [3:0]  CHOOSE_FIFO_3   = 4'b0111,
    parameter logic [3:0]  NON_FIFO_CHOOSE = 4'b0000,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            fifo_req,
    input  logic                  axis_in_0_tvalid,
    input  logic [DATA_WIDTH-1:0] axis_in_0_tdata,
    input  logic                  axis_in_0_tlast,
    input  logic                  axis_in_1_tvalid,
    input  logic [DATA_WIDTH-1:0] axis_in_1_tdata,
    input  logic                  axis_in_1_tlast,
    input  logic                  axis_in_2_tvalid,
    input  logic [DATA_WIDTH-1:0] axis_in_2_tdata,
    input  logic                  axis_in_2_tlast,
    input  logic                  axis_in_3_tvalid,
    input  logic [DATA_WIDTH-1:0] axis_in_3_tdata,
    input  logic                  axis_in_3_tlast,
    output logic                  axis_out_tvalid,
    output logic [DATA_WIDTH-1:0] axis_out_tdata,
    output logic                  axis_out_tlast,
    input  logic                  axis_out_tready,
    output logic [3:0]            bus_sel,
    output logic                  arb_timeout
);

    // Reject parameter sets that would produce an invalid grant code or limit.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 ||
        CHOOSE_FIFO_0 == 4'b0000 || CHOOSE_FIFO_1 == 4'b0000 ||
        CHOOSE_FIFO_2 == 4'b0000 || CHOOSE_FIFO_3 == 4'b0000) begin : g_bad_params
        $error("axis_fifo_arbiter_4_1: invalid parameter set");
    end

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t     state, state_nxt;
    logic [1:0] gnt, gnt_nxt;
    logic [1:0] last_g, last_g_nxt;
    logic [3:0] bus_sel_nxt;
    logic       pick_valid;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       beat_ok;
    logic       last_beat;
    logic       stall_expired;

    function automatic logic [3:0] sel_code(input logic [1:0] idx);
        case (idx)
            2'd0:    return CHOOSE_FIFO_0;
            2'd1:    return CHOOSE_FIFO_1;
            2'd2:    return CHOOSE_FIFO_2;
            default: return CHOOSE_FIFO_3;
        endcase
    endfunction

    // Round-robin search from last_g+1; walking the offsets downwards lets the
    // nearest requester overwrite any farther one.
    always_comb begin : rr_pick
        pick_valid = 1'b0;
        pick       = last_g;
        cand       = last_g;
        for (int i = 4; i >= 1; i--) begin
            cand = last_g + 2'(i);
            if (fifo_req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // Combinational stream mux driven by the registered grant.
    always_comb begin : out_mux
        axis_out_tvalid = 1'b0;
        axis_out_tdata  = '0;
        axis_out_tlast  = 1'b0;
        if (state == ST_GRANT) begin
            case (gnt)
                2'd0: begin
                    axis_out_tvalid = axis_in_0_tvalid;
                    axis_out_tdata  = axis_in_0_tdata;
                    axis_out_tlast  = axis_in_0_tlast;
                end
                2'd1: begin
                    axis_out_tvalid = axis_in_1_tvalid;
                    axis_out_tdata  = axis_in_1_tdata;
                    axis_out_tlast  = axis_in_1_tlast;
                end
                2'd2: begin
                    axis_out_tvalid = axis_in_2_tvalid;
                    axis_out_tdata  = axis_in_2_tdata;
                    axis_out_tlast  = axis_in_2_tlast;
                end
                default: begin
                    axis_out_tvalid = axis_in_3_tvalid;
                    axis_out_tdata  = axis_in_3_tdata;
                    axis_out_tlast  = axis_in_3_tlast;
                end
            endcase
        end
    end

    assign beat_ok   = axis_out_tvalid & axis_out_tready;
    assign last_beat = beat_ok & axis_out_tlast;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt     <= 2'd0;
            last_g  <= 2'd3;
            bus_sel <= NON_FIFO_CHOOSE;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            last_g  <= last_g_nxt;
            bus_sel <= bus_sel_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until tlast or timeout.
    always_comb begin : fsm_next
        state_nxt   = state;
        gnt_nxt     = gnt;
        last_g_nxt  = last_g;
        bus_sel_nxt = bus_sel;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt   = ST_GRANT;
                    gnt_nxt     = pick;
                    last_g_nxt  = pick;
                    bus_sel_nxt = sel_code(pick);
                end
            end
            default: begin
                if (last_beat || stall_expired) begin
                    state_nxt   = ST_IDLE;
                    bus_sel_nxt = NON_FIFO_CHOOSE;
                end
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] stall_cnt;

    // Stall counter: zero outside GRANT and on every accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            arb_timeout <= 1'b0;
        end else begin
            if (state != ST_GRANT || beat_ok) begin
                stall_cnt <= '0;
            end else if (stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            arb_timeout <= (state == ST_GRANT) && stall_expired && !last_beat;
        end
    end

    assign stall_expired = (stall_cnt >= 16'(TIMEOUT_CYCLES));
`else
    assign stall_expired = 1'b0;
    assign arb_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_axis_fifo_arbiter_4_1.sv
// Testbench for axis_fifo_arbiter_4_1: behavioural decoder sources, a
// scoreboard of expected FIFO beats, and scenario tasks.
module tb_axis_fifo_arbiter_4_1;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] data;
        logic       last;
    } exp_t;

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_LEN = 6;
`else
    localparam int STALL_LEN = 50;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] fifo_req;
    logic [3:0] in_tvalid;
    logic [3:0] in_tlast;
    logic [7:0] in_tdata [4];
    logic       axis_out_tvalid;
    logic [7:0] axis_out_tdata;
    logic       axis_out_tlast;
    logic       axis_out_tready;
    logic [3:0] bus_sel;
    logic       arb_timeout;

    beat_t src_q [4][$];
    exp_t  sb [$];
    logic [3:0] fire;
    int n_tests = 0;
    int n_fail  = 0;

    axis_fifo_arbiter_4_1 #(
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_req(fifo_req),
        .axis_in_0_tvalid(in_tvalid[0]),
        .axis_in_0_tdata(in_tdata[0]),
        .axis_in_0_tlast(in_tlast[0]),
        .axis_in_1_tvalid(in_tvalid[1]),
        .axis_in_1_tdata(in_tdata[1]),
        .axis_in_1_tlast(in_tlast[1]),
        .axis_in_2_tvalid(in_tvalid[2]),
        .axis_in_2_tdata(in_tdata[2]),
        .axis_in_2_tlast(in_tlast[2]),
        .axis_in_3_tvalid(in_tvalid[3]),
        .axis_in_3_tdata(in_tdata[3]),
        .axis_in_3_tlast(in_tlast[3]),
        .axis_out_tvalid(axis_out_tvalid),
        .axis_out_tdata(axis_out_tdata),
        .axis_out_tlast(axis_out_tlast),
        .axis_out_tready(axis_out_tready),
        .bus_sel(bus_sel),
        .arb_timeout(arb_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] code_of(input int n);
        return 4'(4 + n);
    endfunction

    // Decoder sources: a beat leaves the source queue when the tready demux
    // (emulated from bus_sel) would have returned tready to it.
    initial begin
        fifo_req  = 4'b0000;
        in_tvalid = 4'b0000;
        in_tlast  = 4'b0000;
        fire      = 4'b0000;
        for (int n = 0; n < 4; n++) in_tdata[n] = 8'h00;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 4; n++)
                fire[n] = (bus_sel == code_of(n)) && axis_out_tready && in_tvalid[n];
            @(posedge clk);
            #1;
            for (int n = 0; n < 4; n++) begin
                if (fire[n] && !rst && src_q[n].size() > 0) src_q[n].delete(0);
                fifo_req[n]  = (src_q[n].size() > 0);
                in_tvalid[n] = (src_q[n].size() > 0);
                in_tdata[n]  = (src_q[n].size() > 0) ? src_q[n][0].data : 8'h00;
                in_tlast[n]  = (src_q[n].size() > 0) ? src_q[n][0].last : 1'b0;
            end
        end
    end

    // Output monitor: every accepted beat must match the scoreboard head.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (!rst && axis_out_tvalid && axis_out_tready) begin
                n_tests++;
                got = {bus_sel, axis_out_tdata, axis_out_tlast};
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat got sel=%b data=%h last=%b, expected none",
                             bus_sel, axis_out_tdata, axis_out_tlast);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL beat got sel=%b data=%h last=%b, expected sel=%b data=%h last=%b",
                                 got.sel, got.data, got.last, e.sel, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic samp;
        @(negedge clk);
        #1;
    endtask

    task automatic push_src(input int n, input int f, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = 8'(n * 64 + f * 8 + i);
            b.last = (i == len - 1);
            src_q[n].push_back(b);
        end
    endtask

    task automatic push_exp(input int n, input int f, input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.sel  = code_of(n);
            e.data = 8'(n * 64 + f * 8 + i);
            e.last = (i == len - 1);
            sb.push_back(e);
        end
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        axis_out_tready = 1'b1;
        for (int n = 0; n < 4; n++) src_q[n].delete();
        sb.delete();
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() > 0; i++) samp;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s drain got %0d beats left, expected 0", name, sb.size());
        end
    endtask

    task automatic check_sel(input string name, input logic [3:0] exp_sel);
        n_tests++;
        if (bus_sel !== exp_sel) begin
            n_fail++;
            $display("FAIL %s bus_sel got %b, expected %b", name, bus_sel, exp_sel);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        axis_out_tready = 1'b1;
        #1 rst = 1'b1;
        #2;
        n_tests++;
        if ({bus_sel, axis_out_tvalid, axis_out_tdata, axis_out_tlast, arb_timeout} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got sel=%b v=%b d=%h l=%b to=%b, expected all 0",
                     bus_sel, axis_out_tvalid, axis_out_tdata, axis_out_tlast, arb_timeout);
        end
        reset_dut;
    endtask

    task automatic test_single;
        reset_dut;
        push_src(2, 0, 3);
        push_exp(2, 0, 3);
        samp;
        check_sel("single_pre_req", 4'b0000);
        samp;
        check_sel("single_req_cycle", 4'b0000);
        samp;
        check_sel("single_grant", 4'b0110);
        wait_drain("single", 20);
        samp;
        check_sel("single_release", 4'b0000);
        n_tests++;
        if (axis_out_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle_tvalid got %b, expected 0", axis_out_tvalid);
        end
    endtask

    task automatic test_contention;
        int idle;
        int i;
        reset_dut;
        push_src(0, 0, 2);
        push_src(0, 1, 2);
        push_src(1, 0, 2);
        push_src(2, 0, 2);
        push_src(3, 0, 2);
        push_exp(0, 0, 2);
        push_exp(1, 0, 2);
        push_exp(2, 0, 2);
        push_exp(3, 0, 2);
        push_exp(0, 1, 2);
        i = 0;
        do begin samp; i++; end while (bus_sel == 4'b0000 && i < 10);
        check_sel("contention_first", 4'b0100);
        idle = 0;
        i = 0;
        while (sb.size() > 0 && i < 60) begin
            samp;
            if (bus_sel == 4'b0000) idle++;
            i++;
        end
        n_tests++;
        if (idle != 4) begin
            n_fail++;
            $display("FAIL contention_idle_gaps got %0d, expected 4", idle);
        end
        wait_drain("contention", 5);
    endtask

    task automatic test_fairness;
        int i;
        reset_dut;
        push_src(1, 0, 4);
        push_src(1, 1, 4);
        push_exp(1, 0, 4);
        repeat (4) samp;
        check_sel("fair_fd1_grant", 4'b0101);
        push_src(3, 0, 2);
        push_exp(3, 0, 2);
        push_exp(1, 1, 4);
        i = 0;
        do begin samp; i++; end while (bus_sel != 4'b0000 && i < 20);
        samp;
        check_sel("fair_fd3_next", 4'b0111);
        wait_drain("fairness", 30);
    endtask

    task automatic test_stall;
        int held;
        int i;
        reset_dut;
        push_src(0, 0, 6);
        push_exp(0, 0, 6);
        i = 0;
        while (sb.size() > 4 && i < 20) begin samp; i++; end
        tick;
        axis_out_tready = 1'b0;
        held = 0;
        for (int k = 0; k < STALL_LEN; k++) begin
            samp;
            if (bus_sel == 4'b0100 && arb_timeout == 1'b0) held++;
        end
        n_tests++;
        if (held != STALL_LEN) begin
            n_fail++;
            $display("FAIL stall_hold got %0d held cycles, expected %0d", held, STALL_LEN);
        end
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL stall_pending got 0 beats left, expected >0");
        end
        tick;
        axis_out_tready = 1'b1;
        wait_drain("stall", 20);
        samp;
        check_sel("stall_release", 4'b0000);
    endtask

    task automatic test_reset_mid;
        int i;
        reset_dut;
        push_src(2, 0, 4);
        push_exp(2, 0, 4);
        i = 0;
        while (sb.size() > 2 && i < 20) begin samp; i++; end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus_sel, axis_out_tvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid got sel=%b tvalid=%b, expected 0000/0", bus_sel, axis_out_tvalid);
        end
        tick;
        for (int n = 0; n < 4; n++) src_q[n].delete();
        sb.delete();
        tick;
        rst = 1'b0;
        push_src(1, 0, 2);
        push_src(3, 0, 2);
        push_exp(1, 0, 2);
        push_exp(3, 0, 2);
        i = 0;
        do begin samp; i++; end while (bus_sel == 4'b0000 && i < 10);
        check_sel("reset_mid_first", 4'b0101);
        wait_drain("reset_mid", 20);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        int i;
        reset_dut;
        axis_out_tready = 1'b0;
        push_src(0, 0, 2);
        push_src(1, 0, 2);
        push_exp(1, 0, 2);
        push_exp(0, 0, 2);
        i = 0;
        do begin samp; i++; end while (bus_sel == 4'b0000 && i < 10);
        check_sel("timeout_grant", 4'b0100);
        i = 0;
        do begin samp; i++; end while (arb_timeout == 1'b0 && i < 20);
        n_tests++;
        if (i != 9) begin
            n_fail++;
            $display("FAIL timeout_latency got %0d, expected 9", i);
        end
        check_sel("timeout_release", 4'b0000);
        samp;
        n_tests++;
        if (arb_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse_width got %b, expected 0", arb_timeout);
        end
        check_sel("timeout_next_fd1", 4'b0101);
        tick;
        axis_out_tready = 1'b1;
        wait_drain("timeout", 30);
    endtask
`endif

    initial begin
        rst = 1'b0;
        axis_out_tready = 1'b1;
        test_reset;
        test_single;
        test_contention;
        test_fairness;
        test_stall;
        test_reset_mid;
`ifdef ARB_TIMEOUT_EN
        test_timeout;
`endif
        repeat (3) samp;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
